cond_unit: RTL
==============

Name: cond_unit

Overview:
- Execute-stage conditional-execution unit, directly downstream of the instruction decoder.
- Registers the decoder's control outputs (PCS, RegW, MemW, FlagW) together with the instruction condition field into a one-entry decode/execute pipeline register.
- Holds the architectural NZCV flags register, evaluates all ARM condition codes, and gates the write enables and PC-source request.
- Generates the branch-shadow squash and keeps executed/skipped instruction counters for debug.

Parameters:
CNT_W, 16, width of the saturating executed/skipped instruction counters
RESET_FLAGS, 4'b0000, NZCV value loaded on reset

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
ValidD  input  1  decode-stage instruction valid
CondD  input  4  instruction condition field, Instr[31:28]
PCSD  input  1  decoder PC-write request
RegWD  input  1  decoder register-write request
MemWD  input  1  decoder memory-write request
FlagWD  input  2  decoder flag-write: [1]=N,Z  [0]=C,V
Stall  input  1  hold execute stage this cycle
Flush  input  1  external flush, insert bubble in execute
ALUFlags  input  4  {N,Z,C,V} from execute-stage ALU, same cycle
PCSrc  output  1  select branch/ALU result as next PC
RegWrite  output  1  gated register-file write enable
MemWrite  output  1  gated data-memory write enable
CondEx  output  1  execute-stage instruction valid and condition passed
Flags  output  4  current committed {N,Z,C,V}
ExecCount  output  CNT_W  instructions executed, saturating
SkipCount  output  CNT_W  valid instructions squashed by a failed condition, saturating

Behaviour:
- E register: ValidE, CondE, PCSE, RegWE, MemWE, FlagWE.
- E register update, priority order:
  - reset: all fields cleared to 0, ValidE=0.
  - else Flush: ValidE<=0, other fields don't-care.
  - else Stall: hold all fields.
  - else PCSrc=1: ValidE<=0 (branch-shadow kill of the instruction in decode).
  - else: load D inputs, ValidE<=ValidD.
- Condition function, Cond(c) over Flags {N,Z,C,V}:
  - EQ 0000 Z; NE 0001 ~Z
  - CS 0010 C; CC 0011 ~C
  - MI 0100 N; PL 0101 ~N
  - VS 0110 V; VC 0111 ~V
  - HI 1000 C&~Z; LS 1001 ~C|Z
  - GE 1010 N==V; LT 1011 N!=V
  - GT 1100 ~Z&(N==V); LE 1101 Z|(N!=V)
  - AL 1110 1; 1111 0 (never)
- Conditions are evaluated against the committed Flags register only; ALUFlags of the current instruction never affect its own condition.
- CondEx = ValidE & Cond(CondE), combinational.
- Gated outputs, combinational, all forced 0 while Stall=1:
  - PCSrc = CondEx & PCSE & ~Stall
  - RegWrite = CondEx & RegWE & ~Stall
  - MemWrite = CondEx & MemWE & ~Stall
- Flags register:
  - Reset value RESET_FLAGS.
  - When CondEx & ~Stall:
    - FlagWE[1]=1: N,Z <= ALUFlags[3:2]
    - FlagWE[0]=1: C,V <= ALUFlags[1:0]
  - Otherwise hold. Failed-condition instructions never update flags.
  - The new value is visible to the next instruction (1-cycle latency).
- Counters, both reset to 0, updated only when ValidE & ~Stall:
  - ExecCount +1 if CondEx.
  - SkipCount +1 if ~CondEx.
  - Both saturate at all-ones; no wrap.
- Flush and Stall together: Flush wins. The E instruction produces no outputs this cycle (gated by Stall) and is discarded.
- Reset mid-stall or mid-branch: reset wins. All outputs are 0 in the cycle after reset is sampled, since ValidE=0.
- PCSrc from a taken branch kills exactly one following instruction. A failed-condition branch kills nothing.

Test Plan:
- Reset with RESET_FLAGS=0 → Flags=0000, ExecCount=0, SkipCount=0, PCSrc/RegWrite/MemWrite=0. Next cycle, load AL RegWD=1 → RegWrite=1, ExecCount=1.
- CMP: FlagWD=11, CondD=1110, ALUFlags=0100 → Flags=0100 next cycle. Following EQ RegWD=1 → RegWrite=1. Following NE MemWD=1 → MemWrite=0, SkipCount increments.
- Exhaustive condition sweep: each Flags value 0000-1111 × each CondD 0000-1111 → CondEx matches the table, including 1111 → 0 and GT/LE with N!=V.
- Taken branch: AL PCSD=1 with ValidD=1 on the next input → PCSrc=1 one cycle. The following instruction has ValidE=0 and produces no RegWrite. Same with CondD=0000, Z=0 → no kill, PCSrc=0.
- Stall=1 for 3 cycles with AL RegWE in E → RegWrite=0 for 3 cycles, Flags and counters held. RegWrite=1 on the first cycle with Stall=0, counted once.
- Preload ExecCount to near-saturation by running 2^CNT_W+2 AL instructions (CNT_W=4 build: 18) → ExecCount=15 held. Flush=Stall=1 together → E emptied, no outputs.

Source files
------------

// File: rtl/cond_if.sv
// Decode-to-execute control bus for the conditional-execution unit.
// The master side is the decoder/hazard logic; the slave side is cond_unit.
interface cond_if #(
    parameter int CNT_W = 16
);
    // Decode-stage control fields
    logic             ValidD;
    logic [3:0]       CondD;
    logic             PCSD;
    logic             RegWD;
    logic             MemWD;
    logic [1:0]       FlagWD;

    // Pipeline control and same-cycle ALU result flags
    logic             Stall;
    logic             Flush;
    logic [3:0]       ALUFlags;

    // Gated execute-stage results
    logic             PCSrc;
    logic             RegWrite;
    logic             MemWrite;
    logic             CondEx;
    logic [3:0]       Flags;
    logic [CNT_W-1:0] ExecCount;
    logic [CNT_W-1:0] SkipCount;

    modport master (
        output ValidD, CondD, PCSD, RegWD, MemWD, FlagWD,
        output Stall, Flush, ALUFlags,
        input  PCSrc, RegWrite, MemWrite, CondEx, Flags, ExecCount, SkipCount
    );

    modport slave (
        input  ValidD, CondD, PCSD, RegWD, MemWD, FlagWD,
        input  Stall, Flush, ALUFlags,
        output PCSrc, RegWrite, MemWrite, CondEx, Flags, ExecCount, SkipCount
    );
endinterface

// File: rtl/cond_unit.sv
// Execute-stage conditional-execution unit: D/E pipeline register for the
// decoder control fields, architectural NZCV register, ARM condition check,
// write-enable gating, branch-shadow kill and debug execute/skip counters.
module cond_unit #(
    parameter int         CNT_W       = 16,
    parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
    input  logic  clk,
    input  logic  reset,
    cond_if.slave bus
);
    // ARM condition field encodings
    localparam logic [3:0] C_EQ = 4'b0000;
    localparam logic [3:0] C_NE = 4'b0001;
    localparam logic [3:0] C_CS = 4'b0010;
    localparam logic [3:0] C_CC = 4'b0011;
    localparam logic [3:0] C_MI = 4'b0100;
    localparam logic [3:0] C_PL = 4'b0101;
    localparam logic [3:0] C_VS = 4'b0110;
    localparam logic [3:0] C_VC = 4'b0111;
    localparam logic [3:0] C_HI = 4'b1000;
    localparam logic [3:0] C_LS = 4'b1001;
    localparam logic [3:0] C_GE = 4'b1010;
    localparam logic [3:0] C_LT = 4'b1011;
    localparam logic [3:0] C_GT = 4'b1100;
    localparam logic [3:0] C_LE = 4'b1101;
    localparam logic [3:0] C_AL = 4'b1110;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // E-stage register fields
    logic             valid_q, valid_d;
    logic [3:0]       cond_q,  cond_d;
    logic             pcs_q,   pcs_d;
    logic             regw_q,  regw_d;
    logic             memw_q,  memw_d;
    logic [1:0]       flagw_q, flagw_d;

    // Architectural state
    logic [3:0]       flags_q, flags_d;
    logic [CNT_W-1:0] exec_q,  exec_d;
    logic [CNT_W-1:0] skip_q,  skip_d;

    logic             flag_n, flag_z, flag_c, flag_v;
    logic             cond_pass;
    logic             cond_ex;
    logic             pcsrc;
    logic             commit;

    assign {flag_n, flag_z, flag_c, flag_v} = flags_q;

    // Condition check against committed flags only; ALUFlags of the
    // instruction in E must never influence its own predicate.
    always_comb begin
        cond_pass = 1'b0;
        unique case (cond_q)
            C_EQ:    cond_pass = flag_z;
            C_NE:    cond_pass = ~flag_z;
            C_CS:    cond_pass = flag_c;
            C_CC:    cond_pass = ~flag_c;
            C_MI:    cond_pass = flag_n;
            C_PL:    cond_pass = ~flag_n;
            C_VS:    cond_pass = flag_v;
            C_VC:    cond_pass = ~flag_v;
            C_HI:    cond_pass = flag_c & ~flag_z;
            C_LS:    cond_pass = ~flag_c | flag_z;
            C_GE:    cond_pass = (flag_n == flag_v);
            C_LT:    cond_pass = (flag_n != flag_v);
            C_GT:    cond_pass = ~flag_z & (flag_n == flag_v);
            C_LE:    cond_pass = flag_z | (flag_n != flag_v);
            C_AL:    cond_pass = 1'b1;
            default: cond_pass = 1'b0;  // 1111: never
        endcase
    end

    assign cond_ex = valid_q & cond_pass;
    // An instruction only takes architectural effect on a non-stalled cycle
    assign commit  = cond_ex & ~bus.Stall;
    assign pcsrc   = commit & pcs_q;

    assign bus.CondEx    = cond_ex;
    assign bus.PCSrc     = pcsrc;
    assign bus.RegWrite  = commit & regw_q;
    assign bus.MemWrite  = commit & memw_q;
    assign bus.Flags     = flags_q;
    assign bus.ExecCount = exec_q;
    assign bus.SkipCount = skip_q;

    // E-register next state: flush beats stall beats branch-shadow kill
    always_comb begin
        valid_d = valid_q;
        cond_d  = cond_q;
        pcs_d   = pcs_q;
        regw_d  = regw_q;
        memw_d  = memw_q;
        flagw_d = flagw_q;
        if (bus.Flush) begin
            valid_d = 1'b0;
        end else if (bus.Stall) begin
            valid_d = valid_q;
        end else if (pcsrc) begin
            // taken branch: the instruction currently in decode is dead
            valid_d = 1'b0;
        end else begin
            valid_d = bus.ValidD;
            cond_d  = bus.CondD;
            pcs_d   = bus.PCSD;
            regw_d  = bus.RegWD;
            memw_d  = bus.MemWD;
            flagw_d = bus.FlagWD;
        end
    end

    // Flag update: each half written independently, only by a passing,
    // non-stalled instruction
    always_comb begin
        flags_d = flags_q;
        if (commit) begin
            if (flagw_q[1]) flags_d[3:2] = bus.ALUFlags[3:2];
            if (flagw_q[0]) flags_d[1:0] = bus.ALUFlags[1:0];
        end
    end

    // Debug counters: every valid non-stalled E instruction lands in
    // exactly one of them; both stick at all-ones
    always_comb begin
        exec_d = exec_q;
        skip_d = skip_q;
        if (valid_q && !bus.Stall) begin
            if (cond_ex) begin
                if (exec_q != CNT_MAX) exec_d = exec_q + 1'b1;
            end else begin
                if (skip_q != CNT_MAX) skip_d = skip_q + 1'b1;
            end
        end
    end

    // D/E pipeline register
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            cond_q  <= 4'b0000;
            pcs_q   <= 1'b0;
            regw_q  <= 1'b0;
            memw_q  <= 1'b0;
            flagw_q <= 2'b00;
        end else begin
            valid_q <= valid_d;
            cond_q  <= cond_d;
            pcs_q   <= pcs_d;
            regw_q  <= regw_d;
            memw_q  <= memw_d;
            flagw_q <= flagw_d;
        end
    end

    // Architectural flags and counters
    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q <= RESET_FLAGS;
            exec_q  <= '0;
            skip_q  <= '0;
        end else begin
            flags_q <= flags_d;
            exec_q  <= exec_d;
            skip_q  <= skip_d;
        end
    end
endmodule
